cnn_frame_ctrl: RTL and testbench

Parametrised successor to the single-shot CNN frame controller. It generates the vsync-delay, hsync-delay and active-data timing for feeding image pixels into the CNN datapath. It adds multi-frame and continuous operation, per-frame shadowing of the configuration, abort, busy/line/frame status, and optional pixel back-pressure. It sits between the register/config interface and the line buffers / convolution engine.

---
 rtl/cnn_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cnn_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_ctrl.sv
// Frame timing controller: vsync gap, per-line hsync gap and pixel beats, with multi-frame runs,
// per-frame shadowed configuration and abort. Optional pixel back-pressure via `CNN_FRAME_CTRL_STALL_EN.
module cnn_frame_ctrl #(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 2*W_SIZE+1,
    parameter int W_DELAY      = 12,
    parameter int W_FRAME_CNT  = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic [W_DELAY-1:0]      q_vsync_delay,
    input  logic [W_DELAY-1:0]      q_hsync_delay,
    input  logic [W_FRAME_CNT-1:0]  q_num_frames,
    input  logic                    q_start,
    input  logic                    q_stop,
`ifdef CNN_FRAME_CTRL_STALL_EN
    input  logic                    i_stall,
`endif
    output logic                    o_ctrl_vsync_run,
    output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
    output logic                    o_ctrl_hsync_run,
    output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
    output logic                    o_ctrl_data_run,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic [W_FRAME_SIZE-1:0] o_data_count,
    output logic                    o_end_line,
    output logic                    o_end_frame,
    output logic [W_FRAME_CNT-1:0]  o_frame_idx,
    output logic                    o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_VSYNC, ST_HSYNC, ST_DATA} state_e;

    state_e                  state_q, state_d;
    logic                    start_prev_q, start_prev_d;
    logic [W_DELAY-1:0]      vcnt_q, vcnt_d, hcnt_q, hcnt_d;
    logic [W_SIZE-1:0]       row_q, row_d, col_q, col_d;
    logic [W_FRAME_SIZE-1:0] dcnt_q, dcnt_d;
    logic [W_FRAME_CNT-1:0]  fidx_q, fidx_d;
    logic [W_SIZE-1:0]       wid_q, wid_d, hgt_q, hgt_d;
    logic [W_DELAY-1:0]      vdly_q, vdly_d, hdly_q, hdly_d;
    logic [W_FRAME_CNT-1:0]  nfrm_q, nfrm_d;

    logic stall, beat, v_last, h_last, col_last, row_last, end_line, end_frame;
    logic start_edge, cfg_ok, more_frames, to_idle;

`ifdef CNN_FRAME_CTRL_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    // A zero delay still costs one cycle in its state.
    assign v_last      = (vdly_q <= W_DELAY'(1)) || (vcnt_q == vdly_q - W_DELAY'(1));
    assign h_last      = (hdly_q <= W_DELAY'(1)) || (hcnt_q == hdly_q - W_DELAY'(1));
    assign col_last    = (col_q == wid_q - W_SIZE'(1));
    assign row_last    = (row_q == hgt_q - W_SIZE'(1));
    assign beat        = (state_q == ST_DATA) && !stall;
    assign end_line    = beat && col_last;
    assign end_frame   = end_line && row_last;
    assign start_edge  = q_start && !start_prev_q;
    assign cfg_ok      = (q_width != '0) && (q_height != '0);
    assign more_frames = (nfrm_q == '0) ||
                         (({1'b0, fidx_q} + (W_FRAME_CNT+1)'(1)) < {1'b0, nfrm_q});

    always_comb begin
        state_d      = state_q;
        start_prev_d = q_start;
        vcnt_d       = vcnt_q;
        hcnt_d       = hcnt_q;
        row_d        = row_q;
        col_d        = col_q;
        dcnt_d       = dcnt_q;
        fidx_d       = fidx_q;
        wid_d        = wid_q;
        hgt_d        = hgt_q;
        vdly_d       = vdly_q;
        hdly_d       = hdly_q;
        nfrm_d       = nfrm_q;
        to_idle      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge && cfg_ok) begin
                    wid_d   = q_width;
                    hgt_d   = q_height;
                    vdly_d  = q_vsync_delay;
                    hdly_d  = q_hsync_delay;
                    nfrm_d  = q_num_frames;
                    fidx_d  = '0;
                    vcnt_d  = '0;
                    state_d = ST_VSYNC;
                end
            end
            ST_VSYNC: begin
                if (v_last) begin
                    row_d   = '0;
                    hcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = ST_HSYNC;
                end else begin
                    vcnt_d = vcnt_q + W_DELAY'(1);
                end
            end
            ST_HSYNC: begin
                if (h_last) begin
                    col_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    hcnt_d = hcnt_q + W_DELAY'(1);
                end
            end
            ST_DATA: begin
                if (beat) begin
                    col_d  = col_q + W_SIZE'(1);
                    dcnt_d = dcnt_q + W_FRAME_SIZE'(1);
                end
                if (end_line && !row_last) begin
                    row_d   = row_q + W_SIZE'(1);
                    hcnt_d  = '0;
                    state_d = ST_HSYNC;
                end else if (end_frame) begin
                    // A re-latched zero-size geometry could never end a line, so it ends the run instead.
                    if (more_frames && cfg_ok) begin
                        fidx_d  = fidx_q + W_FRAME_CNT'(1);
                        wid_d   = q_width;
                        hgt_d   = q_height;
                        vdly_d  = q_vsync_delay;
                        hdly_d  = q_hsync_delay;
                        nfrm_d  = q_num_frames;
                        vcnt_d  = '0;
                        state_d = ST_VSYNC;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (q_stop || to_idle) begin
            state_d = ST_IDLE;
            vcnt_d  = '0;
            hcnt_d  = '0;
            row_d   = '0;
            col_d   = '0;
            dcnt_d  = '0;
            fidx_d  = '0;
        end
    end

    // The edge detector resets high so a start level held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            vcnt_q       <= '0;
            hcnt_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            dcnt_q       <= '0;
            fidx_q       <= '0;
            wid_q        <= '0;
            hgt_q        <= '0;
            vdly_q       <= '0;
            hdly_q       <= '0;
            nfrm_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            vcnt_q       <= vcnt_d;
            hcnt_q       <= hcnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dcnt_q       <= dcnt_d;
            fidx_q       <= fidx_d;
            wid_q        <= wid_d;
            hgt_q        <= hgt_d;
            vdly_q       <= vdly_d;
            hdly_q       <= hdly_d;
            nfrm_q       <= nfrm_d;
        end
    end

    assign o_ctrl_vsync_run = (state_q == ST_VSYNC);
    assign o_ctrl_vsync_cnt = vcnt_q;
    assign o_ctrl_hsync_run = (state_q == ST_HSYNC);
    assign o_ctrl_hsync_cnt = hcnt_q;
    assign o_ctrl_data_run  = beat;
    assign o_row            = row_q;
    assign o_col            = col_q;
    assign o_data_count     = dcnt_q;
    assign o_end_line       = end_line;
    assign o_end_frame      = end_frame;
    assign o_frame_idx      = fidx_q;
    assign o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Bench for cnn_frame_ctrl: table-driven runs, hand-written corner sequences and random runs
// checked cycle by cycle against a frame-schedule model.
module tb_cnn_frame_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [11:0] q_width, q_height, q_vsync_delay, q_hsync_delay;
    logic [7:0]  q_num_frames;
    logic        q_start, q_stop;
`ifdef CNN_FRAME_CTRL_STALL_EN
    logic        i_stall;
`endif
    logic        o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run;
    logic [11:0] o_ctrl_vsync_cnt, o_ctrl_hsync_cnt, o_row, o_col;
    logic [24:0] o_data_count;
    logic        o_end_line, o_end_frame, o_busy;
    logic [7:0]  o_frame_idx;

    cnn_frame_ctrl #(.W_SIZE(12), .W_DELAY(12), .W_FRAME_CNT(8)) dut (
        .clk(clk), .rstn(rstn),
        .q_width(q_width), .q_height(q_height),
        .q_vsync_delay(q_vsync_delay), .q_hsync_delay(q_hsync_delay),
        .q_num_frames(q_num_frames), .q_start(q_start), .q_stop(q_stop),
`ifdef CNN_FRAME_CTRL_STALL_EN
        .i_stall(i_stall),
`endif
        .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt),
        .o_ctrl_hsync_run(o_ctrl_hsync_run), .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt),
        .o_ctrl_data_run(o_ctrl_data_run), .o_row(o_row), .o_col(o_col),
        .o_data_count(o_data_count), .o_end_line(o_end_line), .o_end_frame(o_end_frame),
        .o_frame_idx(o_frame_idx), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vrun;
        logic [11:0] vcnt;
        logic        hrun;
        logic [11:0] hcnt;
        logic        drun;
        logic [11:0] row;
        logic [11:0] col;
        logic [24:0] dcnt;
        logic        el;
        logic        ef;
        logic [7:0]  fidx;
        logic        busy;
    } obs_t;

    typedef struct {
        int w, h, v, hd, nf;
        int exp_busy, exp_ef, exp_last;
    } vec_t;

    obs_t dut_obs;
    assign dut_obs = {o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
                      o_ctrl_data_run, o_row, o_col, o_data_count, o_end_line, o_end_frame,
                      o_frame_idx, o_busy};

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic obs_t mk_v(int k, int f);
        obs_t e = '0;
        e.busy = 1'b1; e.fidx = 8'(f); e.vrun = 1'b1; e.vcnt = 12'(k);
        return e;
    endfunction

    function automatic obs_t mk_h(int k, int r, int f);
        obs_t e = '0;
        e.busy = 1'b1; e.fidx = 8'(f); e.hrun = 1'b1; e.hcnt = 12'(k); e.row = 12'(r);
        return e;
    endfunction

    function automatic obs_t mk_d(int r, int c, int dc, bit run, bit el, bit ef, int f);
        obs_t e = '0;
        e.busy = 1'b1; e.fidx = 8'(f); e.drun = run; e.row = 12'(r); e.col = 12'(c);
        e.dcnt = 25'(dc); e.el = el; e.ef = ef;
        return e;
    endfunction

    // Counters are only meaningful in the state that owns them (all of them are zero when idle).
    function automatic obs_t mask(obs_t o, obs_t e);
        bit idle  = !e.busy;
        bit dstat = e.busy && !e.vrun && !e.hrun;
        if (!(e.vrun || idle)) o.vcnt = '0;
        if (!(e.hrun || idle)) o.hcnt = '0;
        if (!(dstat || e.hrun || idle)) o.row = '0;
        if (!(dstat || idle)) begin o.col = '0; o.dcnt = '0; end
        return o;
    endfunction

    task automatic push_frame(int w, int h, int v, int hd, int f);
        int vv = (v == 0) ? 1 : v;
        int hh = (hd == 0) ? 1 : hd;
        for (int k = 0; k < vv; k++) exp_q.push_back(mk_v(k, f));
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < hh; k++) exp_q.push_back(mk_h(k, r, f));
            for (int c = 0; c < w; c++)
                exp_q.push_back(mk_d(r, c, r*w + c, 1'b1, c == w-1, (c == w-1) && (r == h-1), f));
        end
    endtask

    task automatic check_obs(input string nm, input obs_t e);
        obs_t a, b;
        a = mask(dut_obs, e);
        b = mask(e, e);
        checks++;
        if (a !== b) begin
            failures++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, a, b);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic set_cfg(int w, int h, int v, int hd, int nf);
        q_width = 12'(w); q_height = 12'(h); q_vsync_delay = 12'(v);
        q_hsync_delay = 12'(hd); q_num_frames = 8'(nf);
    endtask

    // Pulses start, walks the expected schedule, optionally changes width / re-pulses start
    // at sample chg_at, optionally aborts at sample stop_at, then expects idle.
    task automatic run_q(input int chg_at, input int chg_w, input int stop_at,
                         output int busy_n, output int ef_n, output int last_dc);
        int n = exp_q.size();
        busy_n = 0; ef_n = 0; last_dc = -1;
        q_start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            q_start = (i == chg_at);
            if (i == chg_at) q_width = 12'(chg_w);
            check_obs("run", exp_q[i]);
            if (o_busy) busy_n++;
            if (o_end_frame) begin ef_n++; last_dc = int'(o_data_count); end
            if (i == stop_at) begin q_stop = 1'b1; break; end
        end
        @(negedge clk);
        q_stop = 1'b0; q_start = 1'b0;
        check_obs("run_end_idle", '0);
        @(negedge clk);
        check_obs("idle_after", '0);
        exp_q.delete();
    endtask

    vec_t tbl[6];
    int   bn, en, ld, stop_idx;
`ifdef CNN_FRAME_CTRL_STALL_EN
    obs_t sq[10];
`endif

    initial begin
        tbl[0] = '{4, 3, 5, 2, 1, 23, 1, 11};
        tbl[1] = '{1, 1, 0, 0, 1, 3, 1, 0};
        tbl[2] = '{2, 2, 1, 3, 2, 22, 2, 3};
        tbl[3] = '{0, 3, 2, 2, 1, 0, 0, -1};
        tbl[4] = '{3, 0, 2, 2, 1, 0, 0, -1};
        tbl[5] = '{5, 1, 3, 1, 3, 27, 3, 4};

        rstn = 1'b0; q_start = 1'b1; q_stop = 1'b0;
`ifdef CNN_FRAME_CTRL_STALL_EN
        i_stall = 1'b0;
`endif
        set_cfg(4, 3, 5, 2, 1);
        repeat (3) @(negedge clk);
        check_obs("reset", '0);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_obs("start_held_through_reset", '0);
        end
        q_start = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            set_cfg(tbl[t].w, tbl[t].h, tbl[t].v, tbl[t].hd, tbl[t].nf);
            if (tbl[t].w != 0 && tbl[t].h != 0)
                for (int f = 0; f < tbl[t].nf; f++)
                    push_frame(tbl[t].w, tbl[t].h, tbl[t].v, tbl[t].hd, f);
            run_q(-1, 0, -1, bn, en, ld);
            check_int($sformatf("tbl%0d_busy_cycles", t), bn, tbl[t].exp_busy);
            check_int($sformatf("tbl%0d_end_frames", t), en, tbl[t].exp_ef);
            check_int($sformatf("tbl%0d_last_count", t), ld, tbl[t].exp_last);
        end

        // Stop together with a start edge in idle: stop wins.
        set_cfg(4, 3, 5, 2, 1);
        q_stop = 1'b1; q_start = 1'b1;
        @(negedge clk);
        check_obs("stop_beats_start", '0);
        q_stop = 1'b0; q_start = 1'b0;
        @(negedge clk);
        check_obs("stop_beats_start_idle", '0);

        // Three frames; width drops to 2 mid frame 0, and a start edge while busy is ignored.
        set_cfg(4, 3, 5, 2, 3);
        push_frame(4, 3, 5, 2, 0);
        push_frame(2, 3, 5, 2, 1);
        push_frame(2, 3, 5, 2, 2);
        run_q(10, 2, -1, bn, en, ld);
        check_int("multi_end_frames", en, 3);
        check_int("multi_last_count", ld, 5);
        check_int("multi_busy_cycles", bn, 23 + 2*(5 + 3*(2+2)));

        // Continuous mode, abort in frame 1 at row 1, col 2.
        set_cfg(4, 3, 2, 1, 0);
        push_frame(4, 3, 2, 1, 0);
        push_frame(4, 3, 2, 1, 1);
        stop_idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (stop_idx < 0 && exp_q[i].drun && exp_q[i].fidx == 8'd1 &&
                exp_q[i].row == 12'd1 && exp_q[i].col == 12'd2)
                stop_idx = i;
        run_q(-1, 0, stop_idx, bn, en, ld);
        check_int("cont_end_frames_before_stop", en, 1);

        // Random geometries checked per cycle and against the closed-form frame length.
        for (int r = 0; r < 8; r++) begin
            int w, h, v, hd, nf, vv, hh;
            w = $urandom_range(1, 6); h = $urandom_range(1, 4);
            v = $urandom_range(0, 4); hd = $urandom_range(0, 3); nf = $urandom_range(1, 3);
            vv = (v == 0) ? 1 : v; hh = (hd == 0) ? 1 : hd;
            set_cfg(w, h, v, hd, nf);
            for (int f = 0; f < nf; f++) push_frame(w, h, v, hd, f);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_q(-1, 0, -1, bn, en, ld);
            check_int($sformatf("rnd%0d_busy_cycles", r), bn, nf*(vv + h*(hh + w)));
            check_int($sformatf("rnd%0d_end_frames", r), en, nf);
            check_int($sformatf("rnd%0d_last_count", r), ld, w*h - 1);
        end

`ifdef CNN_FRAME_CTRL_STALL_EN
        // Stall for three cycles at col 2 of a 4x1 frame.
        set_cfg(4, 1, 1, 1, 1);
        sq[0] = mk_v(0, 0);
        sq[1] = mk_h(0, 0, 0);
        sq[2] = mk_d(0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        sq[3] = mk_d(0, 1, 1, 1'b1, 1'b0, 1'b0, 0);
        sq[4] = mk_d(0, 2, 2, 1'b0, 1'b0, 1'b0, 0);
        sq[5] = mk_d(0, 2, 2, 1'b0, 1'b0, 1'b0, 0);
        sq[6] = mk_d(0, 2, 2, 1'b0, 1'b0, 1'b0, 0);
        sq[7] = mk_d(0, 2, 2, 1'b1, 1'b0, 1'b0, 0);
        sq[8] = mk_d(0, 3, 3, 1'b1, 1'b1, 1'b1, 0);
        sq[9] = '0;
        q_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            q_start = 1'b0;
            i_stall = (i >= 4 && i <= 6);
            @(negedge clk);
            check_obs($sformatf("stall_cycle%0d", i), sq[i]);
        end
        i_stall = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
